// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch_unit: owns the PC, applies PCSrc redirects, fetches one          |
// | instruction at a time and hands it to decode. Option: MISALIGN_TRAP_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      PCSrc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [1:0] c_st_boot = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;
  localparam logic [1:0] c_st_hold = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;

  logic            w_redir;
  logic [XLEN-1:0] w_raw_target;
  logic [XLEN-1:0] w_target;

  assign w_redir      = redirect_valid && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
  assign w_raw_target = (PCSrc == 2'b10) ? (branch_pc + imm)
                                         : ((rs1 + imm) & ~XLEN'(1));

`ifdef MISALIGN_TRAP_EN
  logic            misalign_trap_q, misalign_trap_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            w_misaligned;

  assign w_misaligned = (w_raw_target[1:0] != 2'b00);
  assign w_target     = w_misaligned ? TRAP_VEC : w_raw_target;

  always_comb begin
    misalign_trap_d = 1'b0;
    misalign_addr_d = misalign_addr_q;
    if (w_redir && w_misaligned) begin
      misalign_trap_d = 1'b1;
      misalign_addr_d = w_raw_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_trap_q <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_trap_q <= misalign_trap_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_trap = misalign_trap_q;
  assign misalign_addr = misalign_addr_q;
`else
  logic w_unused_trap_vec;

  // Without trapping, a misaligned target is silently word-aligned.
  assign w_target          = w_raw_target & ~XLEN'(3);
  assign w_unused_trap_vec = ^TRAP_VEC;
  assign misalign_trap     = 1'b0;
  assign misalign_addr     = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      c_st_boot: begin
        state_d = c_st_req;
        if (w_redir) pc_d = w_target;
      end
      c_st_req: begin
        if (imem_req_ready) state_d = c_st_wait;
        if (w_redir) begin
          pc_d = w_target;
          // The request already issued fetches the stale PC; drop its response.
          if (imem_req_ready) squash_d = 1'b1;
        end
      end
      c_st_wait: begin
        if (imem_rsp_valid) begin
          if (w_redir || squash_q) begin
            if (w_redir) pc_d = w_target;
            squash_d = 1'b0;
            state_d  = c_st_req;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = c_st_hold;
          end
        end else if (w_redir) begin
          pc_d     = w_target;
          squash_d = 1'b1;
        end
      end
      c_st_hold: begin
        if (w_redir) begin
          pc_d    = w_target;
          state_d = c_st_req;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = c_st_req;
        end
      end
      default: state_d = c_st_boot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_st_boot;
      pc_q      <= RESET_PC;
      squash_q  <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      squash_q  <= squash_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == c_st_req);
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;
  assign inst_valid     = (state_q == c_st_hold);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit        |
// | against an instruction-stream reference model. Revision: 1.0             |
// +--------------------------------------------------------------------------+
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] TRAP_VEC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        redirect_valid = 1'b0;
  logic [31:0] branch_pc = '0, imm = '0, rs1 = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        inst_ready = 1'b0;
  logic        misalign_trap;
  logic [31:0] misalign_addr;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .redirect_valid(redirect_valid),
    .branch_pc(branch_pc), .imm(imm), .rs1(rs1),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready),
    .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the architectural instruction stream plus a simple memory.
  logic [31:0] exp_pc = RESET_PC;
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_delay = 0;
  logic [31:0] req_log[$];
  int          n_deliv = 0;
  logic [31:0] last_deliv_pc = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        exp_trap = 1'b0;
  logic [31:0] exp_maddr = '0;

  int rdy_pct = 100, irdy_pct = 100, redir_pct = 0, dly_min = 0, dly_max = 0;
  logic        os_valid = 1'b0;
  logic [1:0]  os_src = 2'b00;
  logic [31:0] os_b = '0, os_i = '0, os_r = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] raw_tgt(input logic [1:0] s, input logic [31:0] b,
                                          input logic [31:0] i, input logic [31:0] r);
    return (s == 2'b10) ? (b + i) : ((r + i) & 32'hFFFF_FFFE);
  endfunction

  function automatic logic [31:0] arch_tgt(input logic [31:0] raw);
`ifdef MISALIGN_TRAP_EN
    return (raw[1:0] != 2'b00) ? TRAP_VEC : raw;
`else
    return raw & 32'hFFFF_FFFC;
`endif
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle();
    logic        redir_eff, req_fire, deliver;
    logic [31:0] raw;
    imem_rsp_valid = mem_pending && (mem_delay == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < irdy_pct);
    if (os_valid) begin
      redirect_valid = 1'b1; PCSrc = os_src; branch_pc = os_b; imm = os_i; rs1 = os_r;
      os_valid = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(99) < redir_pct);
      PCSrc     = 2'($urandom_range(3));
      branch_pc = $urandom & 32'h0000_FFFC;
      imm       = ($urandom_range(3) == 0) ? $urandom
                                           : ((32'($urandom_range(127)) - 32'd64) << 2);
      rs1       = $urandom & 32'h0000_FFFF;
    end
    #1;
    check("trap_pulse", {31'b0, misalign_trap}, {31'b0, exp_trap});
    if (exp_trap) check("trap_addr", misalign_addr, exp_maddr);
    if (prev_hold) begin
      check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    redir_eff = redirect_valid && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
    raw       = raw_tgt(PCSrc, branch_pc, imm, rs1);
    req_fire  = imem_req_valid && imem_req_ready;
    deliver   = inst_valid && inst_ready && !redir_eff;
    if (req_fire) begin
      check("one_outstanding", {31'b0, mem_pending}, 32'd0);
      req_log.push_back(imem_req_addr);
    end
    if (deliver) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_word", inst, mem_word(exp_pc));
      last_deliv_pc = exp_pc;
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (redir_eff) exp_pc = arch_tgt(raw);
`ifdef MISALIGN_TRAP_EN
    exp_trap  = redir_eff && (raw[1:0] != 2'b00);
    exp_maddr = raw;
`else
    exp_trap  = 1'b0;
`endif
    prev_hold = imem_req_valid && !imem_req_ready && !redir_eff;
    prev_addr = imem_req_addr;
    if (imem_rsp_valid) mem_pending = 1'b0;
    else if (mem_pending) mem_delay--;
    if (req_fire) begin
      mem_pending = 1'b1;
      mem_addr    = imem_req_addr;
      mem_delay   = $urandom_range(dly_max, dly_min);
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset in mid-cycle; a stale response shows up right after release.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_trap", {31'b0, misalign_trap}, 32'd0);
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    check("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    mem_pending = 1'b0; exp_pc = RESET_PC; req_log.delete();
    prev_hold = 1'b0; exp_trap = 1'b0; os_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held_pc;
    int          k;
    @(posedge clk); #1;
    do_reset();

    // Straight-line fetch: addresses 0,4,8,C.
    rdy_pct = 100; irdy_pct = 100; redir_pct = 0; dly_min = 0; dly_max = 0;
    k = 0;
    while (req_log.size() < 4 && k < 40) begin cycle(); k++; end
    check("seq_count", 32'(req_log.size()), 32'd4);
    if (req_log.size() >= 4) begin
      check("seq_addr0", req_log[0], 32'h0);
      check("seq_addr1", req_log[1], 32'h4);
      check("seq_addr2", req_log[2], 32'h8);
      check("seq_addr3", req_log[3], 32'hC);
    end

    // Branch redirect while holding an instruction, decode ready in the same cycle.
    irdy_pct = 0;
    k = 0;
    while (!inst_valid && k < 40) begin cycle(); k++; end
    check("hold_reached", {31'b0, inst_valid}, 32'd1);
    irdy_pct = 100;
    os_valid = 1'b1; os_src = 2'b10; os_b = 32'h20; os_i = 32'hFFFF_FFF8; os_r = '0;
    cycle();
    check("hold_dropped", {31'b0, inst_valid}, 32'd0);
    req_log.delete();
    k = 0;
    while (req_log.size() == 0 && k < 40) begin cycle(); k++; end
    check("branch_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h18);

    // JALR redirect while a response is outstanding.
    dly_min = 3; dly_max = 3;
    k = 0;
    while (!(mem_pending && mem_delay >= 2) && k < 60) begin cycle(); k++; end
    check("wait_reached", {31'b0, mem_pending}, 32'd1);
    os_valid = 1'b1; os_src = 2'b01; os_b = '0; os_i = 32'h10; os_r = 32'h101;
    cycle();
    req_log.delete();
    k = 0;
    while (req_log.size() == 0 && k < 40) begin cycle(); k++; end
    check("jalr_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h110);
    dly_min = 0; dly_max = 0;
    k = n_deliv;
    for (int n = 0; n < 40 && n_deliv == k; n++) cycle();
    check("jalr_deliv_pc", last_deliv_pc, 32'h110);

    // Decode stall: five cycles of back-pressure in HOLD.
    irdy_pct = 0;
    k = 0;
    while (!inst_valid && k < 40) begin cycle(); k++; end
    held_pc = exp_pc;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("stall_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_pc", inst_pc, held_pc);
      check("stall_inst", inst, mem_word(held_pc));
      check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    irdy_pct = 100;
    req_log.delete();
    k = 0;
    while (req_log.size() == 0 && k < 40) begin cycle(); k++; end
    check("stall_next_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, held_pc + 32'd4);

    // Reset while a response is outstanding.
    dly_min = 3; dly_max = 3;
    k = 0;
    while (!(mem_pending && mem_delay >= 2) && k < 60) begin cycle(); k++; end
    check("wait_reached2", {31'b0, mem_pending}, 32'd1);
    do_reset();
    dly_min = 0; dly_max = 0;
    k = 0;
    while (req_log.size() == 0 && k < 40) begin cycle(); k++; end
    check("post_rst_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, RESET_PC);
    k = n_deliv;
    for (int n = 0; n < 40 && n_deliv == k; n++) cycle();
    check("post_rst_deliv", last_deliv_pc, RESET_PC);

`ifdef MISALIGN_TRAP_EN
    os_valid = 1'b1; os_src = 2'b10; os_b = 32'h20; os_i = 32'h2; os_r = '0;
    cycle();
    check("mis_trap_hi", {31'b0, misalign_trap}, 32'd1);
    check("mis_trap_addr", misalign_addr, 32'h22);
    req_log.delete();
    cycle();
    check("mis_trap_lo", {31'b0, misalign_trap}, 32'd0);
    k = 0;
    while (req_log.size() == 0 && k < 40) begin cycle(); k++; end
    check("mis_trap_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, TRAP_VEC);
`endif

    // Randomized traffic checked against the instruction-stream model.
    rdy_pct = 70; irdy_pct = 70; redir_pct = 8; dly_min = 0; dly_max = 3;
    k = n_deliv;
    for (int n = 0; n < 3000; n++) cycle();
    check("random_progress", {31'b0, (n_deliv - k) > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
